// File: rtl/mdr_mem_ctrl.sv
// rtl/mdr_mem_ctrl.sv - memory data register with a timed read/write handshake
module mdr_mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] busMuxOut,
  input  logic              mdr_in,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter only ever needs to reach MAX_WAIT-1; it is cleared instead of wrapping.
  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] q_r, q_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic              rd_r, rd_n;
  logic              wr_r, wr_n;
  logic              done_r, done_n;
  logic              err_r, err_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;

  // Register all state; clr aborts any access without raising done or err.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      q_r    <= '0;
      addr_r <= '0;
      rd_r   <= 1'b0;
      wr_r   <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      cnt_r  <= '0;
    end else begin
      state  <= state_n;
      q_r    <= q_n;
      addr_r <= addr_n;
      rd_r   <= rd_n;
      wr_r   <= wr_n;
      done_r <= done_n;
      err_r  <= err_n;
      cnt_r  <= cnt_n;
    end
  end

  // Next-state logic: commands only in IDLE (read beats write beats bus load),
  // then wait for ack or give up after MAX_WAIT edges.
  always_comb begin
    state_n = state;
    q_n     = q_r;
    addr_n  = addr_r;
    rd_n    = rd_r;
    wr_n    = wr_r;
    done_n  = 1'b0;
    err_n   = err_r;
    cnt_n   = cnt_r;
    case (state)
      IDLE: begin
        if (read) begin
          state_n = RD;
          addr_n  = mar_addr;
          rd_n    = 1'b1;
          cnt_n   = '0;
          err_n   = 1'b0;
        end else if (write) begin
          state_n = WR;
          addr_n  = mar_addr;
          wr_n    = 1'b1;
          cnt_n   = '0;
          err_n   = 1'b0;
        end else if (mdr_in) begin
          q_n = busMuxOut;
        end
      end
      RD, WR: begin
        if (mem_ack) begin
          if (state == RD) q_n = Mdatain;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_r + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_addr  = addr_r;
  assign mem_rd    = rd_r;
  assign mem_wr    = wr_r;
  assign mem_wdata = q_r;
  assign Q         = q_r;
  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// tb/tb_mdr_mem_ctrl.sv - directed bench for mdr_mem_ctrl with a transaction-level model
module tb_mdr_mem_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] busMuxOut = '0;
  logic          mdr_in = 1'b0;
  logic [AW-1:0] mar_addr = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] Mdatain = '0;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] Q;
  logic          busy, done, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  mdr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .clr(clr), .busMuxOut(busMuxOut), .mdr_in(mdr_in),
    .mar_addr(mar_addr), .read(read), .write(write), .Mdatain(Mdatain),
    .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .Q(Q), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction model: kind 0 = no access, 1 = read, 2 = write; strobes follow kind.
  int            m_kind = 0;
  int            m_edges = 0;
  logic [DW-1:0] m_q = '0;
  logic [AW-1:0] m_addr = '0;
  logic          m_done = 1'b0;
  logic          m_err = 1'b0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_kind = 0; m_edges = 0; m_q = '0; m_addr = '0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_kind == 0) begin
        if (read || write) begin
          m_kind  = read ? 1 : 2;
          m_addr  = mar_addr;
          m_edges = 0;
          m_err   = 1'b0;
        end else if (mdr_in) begin
          m_q = busMuxOut;
        end
      end else if (mem_ack) begin
        if (m_kind == 1) m_q = Mdatain;
        m_done = 1'b1;
        m_kind = 0;
      end else begin
        m_edges++;
        if (m_edges == MW) begin
          m_err  = 1'b1;
          m_kind = 0;
        end
      end
    end
  end

  bit chk_en = 1'b0;
  int rd_hi = 0, wr_hi = 0, done_hi = 0;

  // Per-cycle comparison of every output against the model, plus strobe/pulse tallies.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle", {Q, mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, err},
            {m_q, m_addr, m_kind == 1, m_kind == 2, m_q, m_kind != 0, m_done, m_err});
      if (mem_rd) rd_hi++;
      if (mem_wr) wr_hi++;
      if (done) done_hi++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int rd0, wr0, d0;

  initial begin
    // Reset
    repeat (2) tick();
    check("rst_q", Q, 0);
    check("rst_flags", {mem_rd, mem_wr, busy, done, err}, 5'b0);
    check("rst_addr", mem_addr, 0);
    chk_en = 1'b1;
    clr = 1'b1;
    tick();

    // Bus load
    mdr_in = 1'b1; busMuxOut = 32'hDEADBEEF;
    tick();
    mdr_in = 1'b0;
    check("load_q", Q, 32'hDEADBEEF);
    check("load_busy_done", {busy, done}, 2'b00);

    // Read, ack after two waiting cycles
    rd0 = rd_hi; d0 = done_hi;
    mar_addr = 9'h0A5; read = 1'b1; Mdatain = 32'h12345678;
    tick();
    read = 1'b0;
    check("rd_addr", mem_addr, 9'h0A5);
    check("rd_q_stable", Q, 32'hDEADBEEF);
    repeat (2) tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rd_done", done, 1'b1);
    tick();
    check("rd_q", Q, 32'h12345678);
    check("rd_strobe_cycles", rd_hi - rd0, 3);
    check("rd_done_pulses", done_hi - d0, 1);

    // Write with immediate ack (ack already high in IDLE is ignored)
    mdr_in = 1'b1; busMuxOut = 32'hCAFEF00D;
    tick();
    mdr_in = 1'b0;
    wr0 = wr_hi; d0 = done_hi;
    mar_addr = 9'h1FF; write = 1'b1; mem_ack = 1'b1;
    tick();
    write = 1'b0;
    check("wr_strobe", {mem_wr, mem_addr}, {1'b1, 9'h1FF});
    check("wr_wdata", mem_wdata, 32'hCAFEF00D);
    tick();
    mem_ack = 1'b0;
    tick();
    check("wr_cycles", wr_hi - wr0, 1);
    check("wr_done_pulses", done_hi - d0, 1);
    check("wr_q", Q, 32'hCAFEF00D);

    // Timeout on read
    rd0 = rd_hi; d0 = done_hi;
    mar_addr = 9'h010; read = 1'b1;
    tick();
    read = 1'b0;
    repeat (6) tick();
    check("to_strobe_cycles", rd_hi - rd0, MW);
    check("to_err", err, 1'b1);
    check("to_no_done", done_hi - d0, 0);
    check("to_q", Q, 32'hCAFEF00D);
    mdr_in = 1'b1; busMuxOut = 32'h5555AAAA;
    tick();
    mdr_in = 1'b0;
    check("to_err_sticky", {err, Q}, {1'b1, 32'h5555AAAA});
    write = 1'b1; mem_ack = 1'b1;
    tick();
    write = 1'b0;
    check("to_err_cleared", err, 1'b0);
    tick();
    mem_ack = 1'b0;
    tick();

    // Conflicting commands in IDLE, then ignored read in RD
    wr0 = wr_hi;
    read = 1'b1; write = 1'b1; mdr_in = 1'b1; busMuxOut = 32'hFFFF0000; mar_addr = 9'h033;
    tick();
    write = 1'b0; mdr_in = 1'b0; mar_addr = 9'h100;
    check("cf_rd", {mem_rd, mem_wr}, 2'b10);
    check("cf_q", Q, 32'h5555AAAA);
    tick();
    read = 1'b0;
    check("cf_addr_held", mem_addr, 9'h033);
    Mdatain = 32'h0BADF00D; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("cf_q_read", Q, 32'h0BADF00D);
    check("cf_no_write", wr_hi - wr0, 0);

    // Reset in the middle of a read with ack high
    d0 = done_hi;
    mar_addr = 9'h042; read = 1'b1;
    tick();
    read = 1'b0; mem_ack = 1'b1; Mdatain = 32'h77777777;
    #2 clr = 1'b0;
    #1 check("mid_rst_out", {Q, mem_addr, mem_rd, mem_wr, busy, done, err}, '0);
    tick();
    check("mid_rst_q", Q, 0);
    clr = 1'b1; mem_ack = 1'b0;
    check("mid_rst_no_done", done_hi - d0, 0);
    read = 1'b1; Mdatain = 32'h13572468;
    tick();
    read = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("post_rst_done", done, 1'b1);
    tick();
    check("post_rst_q", Q, 32'h13572468);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
